if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core. Sits directly upstream of the control decoder.
- Owns the PC and issues requests to instruction memory.
- Captures returned instructions into the IF/ID register and drives the 6-bit opcode the control decoder consumes.
- Applies redirects: jumps resolved in ID, taken branches resolved in EX. Load-use stalls from the hazard unit hold the stage.

---
 rtl/if_pkg.sv | 8 +
 rtl/if_stage_if.sv | 10 +
 rtl/if_stage_pc_next_sel.sv | 30 +++
 rtl/if_stage.sv | 127 ++++++++++++
 tb/tb_if_stage.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;
   typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} if_state_t;
   localparam logic [31:0] NOP_INSTR  = 32'h0;
   localparam int          OPCODE_MSB = 31;
   localparam int          OPCODE_LSB = 26;
   localparam int          JIDX_W     = 26;
endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory request/response bus
interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/if_stage_pc_next_sel.sv
// rtl/if_stage_pc_next_sel.sv - redirect decision and next-pc selection
module pc_next_sel
   import if_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]   pc,
   input  logic              stall_if,
   input  logic              branch_taken,
   input  logic [XLEN-1:0]   branch_target,
   input  logic              jump,
   input  logic              ifid_valid,
   input  logic [3:0]        pc4_hi,
   input  logic [JIDX_W-1:0] jidx,
   output logic [XLEN-1:0]   pc_plus4,
   output logic [XLEN-1:0]   pc_next,
   output logic              redir
);
   // Branch is from the older instruction, so it beats a jump sitting in IF/ID.
   always_comb begin
      pc_plus4 = pc + XLEN'(4);
      redir    = branch_taken | (jump & ifid_valid & ~stall_if);
      if (branch_taken)
         pc_next = branch_target & ~XLEN'(3);
      else if (redir)
         pc_next = {pc4_hi, jidx, 2'b00};
      else
         pc_next = pc_plus4;
   end
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS fetch stage: pc, imem requests, IF/ID register
module if_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_if,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump,
   if_stage_if.master      imem,
   output logic [XLEN-1:0] ifid_instr,
   output logic [XLEN-1:0] ifid_pc4,
   output logic            ifid_valid,
   output logic [5:0]      opcode
);
   if_state_t       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, hold_q, hold_d;
   logic [XLEN-1:0] instr_d, pc4_d;
   logic            valid_d;
   logic [XLEN-1:0] pc_plus4, pc_next;
   logic            redir;

   pc_next_sel #(.XLEN(XLEN)) u_sel (
      .pc            (pc_q),
      .stall_if      (stall_if),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .ifid_valid    (ifid_valid),
      .pc4_hi        (ifid_pc4[31:28]),
      .jidx          (ifid_instr[JIDX_W-1:0]),
      .pc_plus4      (pc_plus4),
      .pc_next       (pc_next),
      .redir         (redir)
   );

   assign opcode = ifid_instr[OPCODE_MSB:OPCODE_LSB];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         hold_q     <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         hold_q     <= hold_d;
         ifid_instr <= instr_d;
         ifid_pc4   <= pc4_d;
         ifid_valid <= valid_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      hold_d         = hold_q;
      instr_d        = ifid_instr;
      pc4_d          = ifid_pc4;
      valid_d        = ifid_valid;
      imem.imem_req  = 1'b0;
      imem.imem_addr = pc_q;
      // Unless overwritten by a load below, an unstalled or flushed IF/ID becomes a bubble.
      if (redir || !stall_if) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end
      case (state_q)
         FETCH: begin
            imem.imem_req = 1'b1;
            if (redir) begin
               pc_d    = pc_next;
               state_d = DISCARD;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem.imem_valid) begin
               if (redir) begin
                  pc_d    = pc_next;
                  state_d = FETCH;
               end else if (stall_if) begin
                  hold_d  = imem.imem_rdata;
                  state_d = HOLD;
               end else begin
                  instr_d        = imem.imem_rdata;
                  pc4_d          = pc_plus4;
                  valid_d        = 1'b1;
                  imem.imem_req  = 1'b1;
                  imem.imem_addr = pc_plus4;
                  pc_d           = pc_plus4;
               end
            end else if (redir) begin
               pc_d    = pc_next;
               state_d = DISCARD;
            end
         end
         HOLD: begin
            if (redir) begin
               pc_d    = pc_next;
               state_d = FETCH;
            end else if (!stall_if) begin
               instr_d = hold_q;
               pc4_d   = pc_plus4;
               valid_d = 1'b1;
               pc_d    = pc_plus4;
               state_d = FETCH;
            end
         end
         DISCARD: begin
            if (redir)
               pc_d = pc_next;
            if (imem.imem_valid)
               state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized scoreboard bench for if_stage
module tb_if_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_if, branch_taken, jump;
   logic [31:0] branch_target;
   logic [31:0] ifid_instr, ifid_pc4, w_instr, w_pc4;
   logic        ifid_valid, w_valid;
   logic [5:0]  opcode, w_opcode;

   if_stage_if mif();
   if_stage_if mw();

   if_stage dut (
      .clk(clk), .rst_n(rst_n), .stall_if(stall_if), .branch_taken(branch_taken),
      .branch_target(branch_target), .jump(jump), .imem(mif),
      .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .opcode(opcode)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst_n(rst_n), .stall_if(1'b0), .branch_taken(1'b0),
      .branch_target(32'h0), .jump(1'b0), .imem(mw),
      .ifid_instr(w_instr), .ifid_pc4(w_pc4), .ifid_valid(w_valid), .opcode(w_opcode)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_fail = 0;
   int          cyc = 0, resp_cyc = 0, lat_fixed = 1, ndel = 0, w_n = 0;
   logic        outst = 1'b0, w_out = 1'b0, s_req, found;
   logic [31:0] out_addr = 32'h0, w_addr = 32'h0, s_addr;
   logic [31:0] exp_pc = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0;
   logic        m_valid = 1'b0;
   logic [31:0] w_log [4];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:         return 32'h8C01_0004;
         32'h4:         return 32'h2002_0005;
         32'h8:         return 32'h0000_0000;
         32'h1000_0004: return 32'h0800_0040;
         default:       return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
      endcase
   endfunction

   // One clock: drive at negedge, act as memory, then score IF/ID after the edge.
   task automatic cycle(input logic st, input logic br, input logic [31:0] bt, input logic jp);
      logic        redir;
      logic [31:0] tgt;
      stall_if        = st;
      branch_taken    = br;
      branch_target   = bt;
      jump            = jp;
      mif.imem_valid  = outst && (cyc == resp_cyc);
      mif.imem_rdata  = mif.imem_valid ? mem_word(out_addr) : $urandom;
      mw.imem_valid   = w_out;
      mw.imem_rdata   = mem_word(w_addr);
      #1;
      s_req  = mif.imem_req;
      s_addr = mif.imem_addr;
      redir  = br | (jp & m_valid & ~st);
      tgt    = br ? {bt[31:2], 2'b00} : {m_pc4[31:28], m_instr[25:0], 2'b00};
      if (mif.imem_valid) outst = 1'b0;
      if (s_req) begin
         check_eq("single_outstanding", outst, 0);
         check_eq("addr_align", s_addr[1:0], 0);
         outst    = 1'b1;
         out_addr = s_addr;
         resp_cyc = cyc + ((lat_fixed != 0) ? lat_fixed : $urandom_range(1, 3));
      end
      if (mw.imem_valid) w_out = 1'b0;
      if (mw.imem_req) begin
         w_out  = 1'b1;
         w_addr = mw.imem_addr;
         if (w_n < 4) begin
            w_log[w_n] = mw.imem_addr;
            w_n++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (redir) begin
         check_eq("flush_valid", ifid_valid, 0);
         check_eq("flush_instr", ifid_instr, 0);
         m_valid = 1'b0;
         m_instr = 32'h0;
         exp_pc  = tgt;
      end else if (st) begin
         check_eq("stall_valid", ifid_valid, m_valid);
         check_eq("stall_instr", ifid_instr, m_instr);
         if (m_valid) check_eq("stall_pc4", ifid_pc4, m_pc4);
      end else if (ifid_valid) begin
         check_eq("instr", ifid_instr, mem_word(exp_pc));
         check_eq("pc4", ifid_pc4, exp_pc + 32'd4);
         check_eq("opcode", opcode, mem_word(exp_pc) >> 26);
         m_valid = 1'b1;
         m_instr = mem_word(exp_pc);
         m_pc4   = exp_pc + 32'd4;
         exp_pc  = exp_pc + 32'd4;
         ndel++;
      end else begin
         check_eq("bubble_instr", ifid_instr, 0);
         m_valid = 1'b0;
         m_instr = 32'h0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; stall_if = 1'b0; branch_taken = 1'b0; jump = 1'b0; branch_target = 32'h0;
      mif.imem_valid = 1'b0; mif.imem_rdata = 32'h0; mw.imem_valid = 1'b0; mw.imem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      check_eq("rst_valid", ifid_valid, 0);
      check_eq("rst_instr", ifid_instr, 0);
      check_eq("rst_pc4", ifid_pc4, 0);
      check_eq("rst_opcode", opcode, 0);
      rst_n = 1'b1;

      // straight-line fetch with 1-cycle memory
      cycle(0, 0, 0, 0);
      check_eq("first_req", s_req, 1);
      check_eq("first_addr", s_addr, 32'h0);
      cycle(0, 0, 0, 0);
      check_eq("addr_4", s_addr, 32'h4);
      check_eq("pc4_4", ifid_pc4, 32'h4);
      check_eq("op_23", opcode, 6'h23);
      check_eq("wrap_pc4", w_pc4, 32'h0);
      check_eq("wrap_valid", w_valid, 1);
      cycle(0, 0, 0, 0);
      check_eq("addr_8", s_addr, 32'h8);
      check_eq("pc4_8", ifid_pc4, 32'h8);
      check_eq("op_08", opcode, 6'h08);
      check_eq("wrap_addr0", w_log[0], 32'hFFFF_FFFC);
      check_eq("wrap_addr1", w_log[1], 32'h0);

      // stall while the response for 8 returns
      cycle(1, 0, 0, 0);
      check_eq("hold_no_req", s_req, 0);
      cycle(1, 0, 0, 0);
      check_eq("hold_pc4", ifid_pc4, 32'h8);
      cycle(0, 0, 0, 0);
      check_eq("release_pc4", ifid_pc4, 32'hC);
      cycle(0, 0, 0, 0);
      check_eq("no_refetch", s_addr, 32'hC);

      // jump from IF/ID
      cycle(0, 1, 32'h1000_0004, 0);
      for (int i = 0; i < 8 && !(m_valid && m_pc4 == 32'h1000_0008); i++) cycle(0, 0, 0, 0);
      check_eq("j_setup", m_pc4, 32'h1000_0008);
      cycle(0, 0, 0, 1);
      check_eq("j_bubble", ifid_valid, 0);
      cycle(0, 0, 0, 0);
      check_eq("j_addr", s_addr, 32'h1000_0100);

      // branch during WAIT with 3-cycle memory
      lat_fixed = 3;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0, 0);
         if (s_req) break;
      end
      cycle(0, 1, 32'h200, 0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle(0, 0, 0, 0);
         if (s_req) begin
            check_eq("br_addr", s_addr, 32'h200);
            found = 1'b1;
         end
      end
      check_eq("br_refetch_seen", found, 1);

      // branch and jump together
      lat_fixed = 1;
      cycle(0, 1, 32'h80, 1);
      check_eq("bj_bubble", ifid_valid, 0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle(0, 0, 0, 0);
         if (s_req) begin
            check_eq("bj_addr", s_addr, 32'h80);
            found = 1'b1;
         end
      end
      check_eq("bj_refetch_seen", found, 1);

      lat_fixed = 0;
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] bt;
         bt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, bt, $urandom_range(0, 11) == 0);
      end
      check_eq("progress", ndel > 100, 1);

      // asynchronous reset while a request is outstanding
      lat_fixed = 3;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         cycle(0, 0, 0, 0);
         found = s_req;
      end
      check_eq("mid_wait_reached", found, 1);
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", ifid_valid, 0);
      check_eq("arst_instr", ifid_instr, 0);
      check_eq("arst_pc4", ifid_pc4, 0);
      check_eq("arst_opcode", opcode, 0);
      outst = 1'b0; w_out = 1'b0; exp_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      lat_fixed = 1;
      cycle(0, 0, 0, 0);
      check_eq("arst_req", s_req, 1);
      check_eq("arst_addr", s_addr, 32'h0);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
